// File: rtl/lane_permute_reg_if.sv
// Stream bundle for lane_permute_reg.
// Input side: in_valid/in_ready/in_data plus per-beat mode and rot_amt.
// Output side: out_valid/out_ready/out_data plus out_mode and the xfer_cnt transfer counter.
// The slave modport is the permute stage. The master modport is whoever drives its inputs.
interface lane_permute_reg_if #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  localparam int RW = ($clog2(LANES) > 1) ? $clog2(LANES) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_data;
  logic [1:0]           mode;
  logic [RW-1:0]        rot_amt;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [1:0]           out_mode;
  logic [CNT_W-1:0]     xfer_cnt;

  modport master (
    output in_valid, in_data, mode, rot_amt, out_ready,
    input  in_ready, out_valid, out_data, out_mode, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, rot_amt, out_ready,
    output in_ready, out_valid, out_data, out_mode, xfer_cnt
  );
endinterface

// File: rtl/lane_permute_reg.sv
// Registered lane-permutation stage with a 2-entry skid buffer.
// Each accepted beat is permuted according to its mode and then stored already permuted:
//   0 = pass, 1 = reverse, 2 = rotate by rot_amt mod LANES, 3 = pair-swap.
//   With pair-swap and an odd LANES, the last lane passes through unchanged.
// Ports:
//   clk   - rising-edge clock.
//   reset - asynchronous, active-high reset.
//   bus   - lane_permute_reg_if.slave, carrying the in_*, out_*, mode, rot_amt and xfer_cnt signals.
// in_ready comes straight from a flop, so it does not depend combinationally on any input.
module lane_permute_reg #(
  parameter int LANES = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  lane_permute_reg_if.slave    bus
);
  localparam int unsigned NL = LANES;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_ROT  = 2'd2,
    MODE_SWAP = 2'd3
  } mode_e;

  // Occupancy states:
  //   S_EMPTY - nothing held.
  //   S_FULL  - the output register holds a beat.
  //   S_SKID  - the output register and the skid register both hold a beat.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e               state, state_n;
  logic [LANES*W-1:0]   perm;
  logic [LANES*W-1:0]   out_data_q, skid_data_q;
  logic [1:0]           out_mode_q, skid_mode_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_q;
  logic                 accept, drain;
  logic                 load_in, load_skid, load_from_skid;

  always_comb begin : permute
    int unsigned src;
    perm = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      src = i;
      case (mode_e'(bus.mode))
        MODE_REV:  src = NL - 1 - i;
        MODE_ROT:  src = (i + 32'(bus.rot_amt)) % NL;
        MODE_SWAP: begin
          if (i[0] == 1'b0) src = (i + 1 < NL) ? i + 1 : i;
          else              src = i - 1;
        end
        default:   src = i;
      endcase
      perm[i*W +: W] = bus.in_data[src*W +: W];
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = (state != S_EMPTY) & bus.out_ready;

  // No case below needs to handle an accept in S_SKID: in_ready_q is already low there.
  always_comb begin : next_state
    state_n        = state;
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          state_n = S_FULL;
          load_in = 1'b1;
        end
      end
      S_FULL: begin
        if (accept && !drain) begin
          state_n   = S_SKID;
          load_skid = 1'b1;
        end else if (accept) begin
          load_in = 1'b1;
        end else if (drain) begin
          state_n = S_EMPTY;
        end
      end
      S_SKID: begin
        if (drain) begin
          state_n        = S_FULL;
          load_from_skid = 1'b1;
        end
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != S_SKID);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_mode_q  <= '0;
      skid_data_q <= '0;
      skid_mode_q <= '0;
      cnt_q       <= '0;
    end else begin
      if (load_in) begin
        out_data_q <= perm;
        out_mode_q <= bus.mode;
      end else if (load_from_skid) begin
        out_data_q <= skid_data_q;
        out_mode_q <= skid_mode_q;
      end
      if (load_skid) begin
        skid_data_q <= perm;
        skid_mode_q <= bus.mode;
      end
      if (drain) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != S_EMPTY);
  assign bus.out_data  = out_data_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_lane_permute_reg.sv
// Scoreboard bench for lane_permute_reg.
// Two instances are exercised:
//   dut_a - LANES=4, W=8, CNT_W=4 (a small counter so that wrap is reachable).
//   dut_b - LANES=3, W=4 (odd lane count).
// Stimulus tasks push each expected beat when the handshake is seen. Monitors pop and compare on every output transfer.
module tb_lane_permute_reg;
  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   strm_on = 0;
  int   strm_ov = 0;
  int   strm_irlow = 0;

  lane_permute_reg_if #(.LANES(4), .W(8), .CNT_W(4))  ifa ();
  lane_permute_reg_if #(.LANES(3), .W(4), .CNT_W(16)) ifb ();

  lane_permute_reg #(.LANES(4), .W(8), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  lane_permute_reg #(.LANES(3), .W(4), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference: gather the lanes into an array and pick each output lane's source lane directly from the rules.
  function automatic logic [31:0] model(input int lanes, input int w, input logic [31:0] d,
                                        input int m, input int r);
    logic [31:0] lane [8];
    logic [31:0] res;
    int src;
    res = '0;
    for (int i = 0; i < lanes; i++) lane[i] = (d >> (i*w)) & ((32'd1 << w) - 32'd1);
    for (int i = 0; i < lanes; i++) begin
      case (m)
        1: src = lanes - 1 - i;
        2: src = (i + r) % lanes;
        3: src = (i % 2 == 0) ? ((i + 1 < lanes) ? i + 1 : i) : i - 1;
        default: src = i;
      endcase
      res = res | (lane[src] << (i*w));
    end
    return res;
  endfunction

  // Called at posedge+1. Holds the beat until a negedge shows in_ready, then pushes the expected result.
  task automatic send_a(input logic [31:0] d, input logic [1:0] m, input logic [1:0] r,
                        input bit use_exp, input logic [31:0] exp);
    exp_t e;
    int k;
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.mode = m; ifa.rot_amt = r;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifa.in_ready) break;
    end
    if (k == 200) begin
      n_checks++; n_fail++;
      $display("FAIL a_accept_timeout: actual=no in_ready required=in_ready within 200 cycles");
    end else begin
      e.data = use_exp ? exp : model(4, 8, d, int'(m), int'(r));
      e.mode = m;
      qa.push_back(e);
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [11:0] d, input logic [1:0] m, input logic [1:0] r,
                        input bit use_exp, input logic [31:0] exp);
    exp_t e;
    int k;
    ifb.in_valid = 1'b1; ifb.in_data = d; ifb.mode = m; ifb.rot_amt = r;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifb.in_ready) break;
    end
    if (k == 200) begin
      n_checks++; n_fail++;
      $display("FAIL b_accept_timeout: actual=no in_ready required=in_ready within 200 cycles");
    end else begin
      e.data = use_exp ? exp : model(3, 4, {20'd0, d}, int'(m), int'(r));
      e.mode = m;
      qb.push_back(e);
    end
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
  endtask

  task automatic drain_a();
    for (int k = 0; k < 100 && qa.size() != 0; k++) @(negedge clk);
    check("a_drain_empty", qa.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    for (int k = 0; k < 100 && qb.size() != 0; k++) @(negedge clk);
    check("b_drain_empty", qb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    reset = 1'b1;
    qa.delete(); qb.delete();
    cnt_a = 0; cnt_b = 0;
    #2;
    check("rst_a_out_valid", ifa.out_valid, 0);
    check("rst_a_in_ready",  ifa.in_ready, 1);
    check("rst_a_xfer_cnt",  ifa.xfer_cnt, 0);
    check("rst_a_out_data",  ifa.out_data, 0);
    check("rst_a_out_mode",  ifa.out_mode, 0);
    check("rst_b_out_valid", ifb.out_valid, 0);
    check("rst_b_in_ready",  ifb.in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Monitor for dut_a: scoreboard compare, xfer_cnt tracking, and hold-under-stall check.
  initial begin : mon_a
    exp_t e;
    bit stall = 0;
    logic [31:0] last = '0;
    logic [1:0] last_m = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 0;
      end else begin
        if (stall) begin
          check("a_hold_valid", ifa.out_valid, 1);
          check("a_hold_data", ifa.out_data, last);
          check("a_hold_mode", ifa.out_mode, last_m);
        end
        if (ifa.out_valid && ifa.out_ready) begin
          if (qa.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL a_unexpected_beat: actual=%0h required=no beat", ifa.out_data);
          end else begin
            e = qa.pop_front();
            check("a_out_data", ifa.out_data, e.data);
            check("a_out_mode", ifa.out_mode, e.mode);
          end
          check("a_xfer_cnt", ifa.xfer_cnt, 64'(cnt_a % 16));
          cnt_a++;
        end
        stall = ifa.out_valid && !ifa.out_ready;
        last = ifa.out_data;
        last_m = ifa.out_mode;
      end
      if (strm_on) begin
        if (ifa.out_valid) strm_ov++;
        if (!ifa.in_ready) strm_irlow++;
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_beat: actual=%0h required=no beat", ifb.out_data);
        end else begin
          e = qb.pop_front();
          check("b_out_data", ifb.out_data, e.data);
          check("b_out_mode", ifb.out_mode, e.mode);
        end
        check("b_xfer_cnt", ifb.xfer_cnt, 64'(cnt_b % 65536));
        cnt_b++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit rnd_done;
    int gap;
    ifa.in_valid = 0; ifa.in_data = '0; ifa.mode = '0; ifa.rot_amt = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.mode = '0; ifb.rot_amt = '0; ifb.out_ready = 1'b1;
    #1;
    do_reset();

    // Directed permutation vectors. The first one also checks the one-cycle latency.
    send_a(32'h44332211, 2'd0, 2'd0, 1, 32'h44332211);
    @(negedge clk);
    check("latency_out_valid", ifa.out_valid, 1);
    @(posedge clk); #1;
    send_a(32'h44332211, 2'd1, 2'd0, 1, 32'h11223344);
    send_a(32'h44332211, 2'd2, 2'd1, 1, 32'h11443322);
    send_a(32'h44332211, 2'd3, 2'd0, 1, 32'h33441122);
    drain_a();

    // Skid: A is held on the output and B sits in the skid, so C must stall.
    do_reset();
    ifa.out_ready = 1'b0;
    send_a(32'h0000000A, 2'd0, 2'd0, 1, 32'h0000000A);
    send_a(32'h0000000B, 2'd0, 2'd0, 1, 32'h0000000B);
    @(negedge clk);
    check("skid_in_ready_low", ifa.in_ready, 0);
    check("skid_out_holds_a", ifa.out_data, 32'h0000000A);
    @(posedge clk); #1;
    fork
      send_a(32'h0000000C, 2'd0, 2'd0, 1, 32'h0000000C);
      begin
        repeat (3) begin
          @(negedge clk);
          check("skid_c_stalled", ifa.in_ready, 0);
        end
        @(posedge clk); #1;
        ifa.out_ready = 1'b1;
      end
    join
    drain_a();
    check("skid_xfer_cnt_3", ifa.xfer_cnt, 3);

    // Streaming 8 beats with out_ready held high.
    strm_ov = 0; strm_irlow = 0; strm_on = 1;
    for (int i = 0; i < 8; i++)
      send_a($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, '0);
    repeat (2) @(negedge clk);
    strm_on = 0;
    check("stream_out_valid_cycles", strm_ov, 8);
    check("stream_in_ready_drops", strm_irlow, 0);
    @(posedge clk); #1;
    drain_a();

    // Reset while the output and skid are both occupied.
    ifa.out_ready = 1'b0;
    send_a(32'hDEADBEEF, 2'd1, 2'd0, 0, '0);
    send_a(32'hCAFEF00D, 2'd3, 2'd0, 0, '0);
    do_reset();
    ifa.out_ready = 1'b1;
    send_a(32'h55667788, 2'd1, 2'd0, 1, 32'h88776655);
    drain_a();

    // Counter wrap: 17 transfers on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++)
      send_a($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, '0);
    drain_a();
    check("wrap_xfer_cnt", ifa.xfer_cnt, 1);

    // Random traffic with random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send_a($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, '0);
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          ifa.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ifa.out_ready = 1'b1;
    drain_a();

    // Odd lane count.
    send_b(12'h321, 2'd3, 2'd0, 1, 32'h312);
    send_b(12'h321, 2'd2, 2'd3, 1, 32'h321);
    for (int i = 0; i < 12; i++)
      send_b(12'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, '0);
    drain_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
